// File: rtl/regs_writeback_pkg.sv
// Shared definitions for the register write-back block: FSM encodings,
// the fixed bus count and the group-index width helper.
package regs_writeback_pkg;

    // Number of result buses; fixed by the r0..r3 port list.
    localparam int OUTPUTS = 4;

    // FSM state encodings.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_WRITE = 1'b1;

    // Width of a group index: one group is the set of registers one bus lane-set covers.
    function automatic int grp_width(input int regs_inputs, input int outputs_per_bus);
        return $clog2(regs_inputs / outputs_per_bus);
    endfunction

endpackage

// File: rtl/regs_writeback_if.sv
// Write-back bus between the input selector and the register bank:
// selected result buses and their destinations in, bank image and status out.
interface regs_writeback_if #(
    parameter int DATA_WIDTH      = 4,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS_PER_BUS = 4
);
    localparam int OUTPUTS = regs_writeback_pkg::OUTPUTS;
    localparam int GRP_W   = regs_writeback_pkg::grp_width(REGS_INPUTS, OUTPUTS_PER_BUS);
    localparam int BUS_W   = DATA_WIDTH * OUTPUTS_PER_BUS;

    logic                            wValid;
    logic [BUS_W-1:0]                r0;
    logic [BUS_W-1:0]                r1;
    logic [BUS_W-1:0]                r2;
    logic [BUS_W-1:0]                r3;
    logic [OUTPUTS*GRP_W-1:0]        wDest;
    logic [OUTPUTS-1:0]              wWrEn;
    logic                            wClear;
    logic                            wBusy;
    logic                            wDone;
    logic [REGS_INPUTS*DATA_WIDTH-1:0] wRegs;

    // Producer side (selector / testbench).
    modport master (
        output wValid, r0, r1, r2, r3, wDest, wWrEn, wClear,
        input  wBusy, wDone, wRegs
    );

    // Write-back block side.
    modport slave (
        input  wValid, r0, r1, r2, r3, wDest, wWrEn, wClear,
        output wBusy, wDone, wRegs
    );

endinterface

// File: rtl/regs_bank.sv
// Register bank with a single group-wide write port and a synchronous
// whole-bank clear. The bank is exported flat.
module regs_bank
    import regs_writeback_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS_PER_BUS = 4
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                wr_en,
    input  logic [grp_width(REGS_INPUTS, OUTPUTS_PER_BUS)-1:0] wr_grp,
    input  logic [DATA_WIDTH*OUTPUTS_PER_BUS-1:0] wr_data,
    input  logic                                clear,
    output logic [REGS_INPUTS*DATA_WIDTH-1:0]   regs
);

    localparam int BUS_W = DATA_WIDTH * OUTPUTS_PER_BUS;

    logic [REGS_INPUTS*DATA_WIDTH-1:0] bank;

    // Bank storage: clear beats write; one group of OUTPUTS_PER_BUS registers per write.
    // NOTE: the bank sits on the async reset because its contents are architecturally
    // visible on wRegs right after reset; a RAM-style array without reset would leak X.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank <= '0;
        end else if (clear) begin
            bank <= '0;
        end else if (wr_en) begin
            bank[int'(wr_grp)*BUS_W +: BUS_W] <= wr_data;
        end
    end

    assign regs = bank;

endmodule

// File: rtl/regs_writeback.sv
// Write-back sequencer: captures the four result buses on an accepted wValid,
// then drains them into the bank one bus per cycle (bus 0 first), skipping
// disabled buses but still spending their slot. wClear wipes the bank and
// aborts any sequence in flight.
module regs_writeback
    import regs_writeback_pkg::*;
#(
    parameter int DATA_WIDTH      = 4,
    parameter int REGS_INPUTS     = 64,
    parameter int OUTPUTS_PER_BUS = 4
) (
    input  logic             clk,
    input  logic             reset,
    regs_writeback_if.slave  bus
);

    localparam int GRP_W = grp_width(REGS_INPUTS, OUTPUTS_PER_BUS);
    localparam int BUS_W = DATA_WIDTH * OUTPUTS_PER_BUS;
    localparam int PTR_W = $clog2(OUTPUTS);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTPUTS - 1);

    logic [0:0]               state;
    logic [PTR_W-1:0]         ptr;
    logic [BUS_W-1:0]         held_bus [OUTPUTS];
    logic [OUTPUTS*GRP_W-1:0] held_dest;
    logic [OUTPUTS-1:0]       held_en;
    logic                     done;

    logic                     accept;
    logic                     wr_en;
    logic [GRP_W-1:0]         wr_grp;
    logic [BUS_W-1:0]         wr_data;

    // A new sequence starts only from IDLE; a clear in the same cycle wins and drops it.
    assign accept = (state == ST_IDLE) && bus.wValid && !bus.wClear;

    // FSM, bus pointer and holding registers; held data is frozen while writing.
    // NOTE: every register here uses <= so all of them see the pre-edge values of
    // state/ptr; blocking assignments would let later lines observe updated state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            ptr       <= '0;
            held_dest <= '0;
            held_en   <= '0;
            done      <= 1'b0;
            for (int i = 0; i < OUTPUTS; i++) begin
                held_bus[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        held_bus[0] <= bus.r0;
                        held_bus[1] <= bus.r1;
                        held_bus[2] <= bus.r2;
                        held_bus[3] <= bus.r3;
                        held_dest   <= bus.wDest;
                        held_en     <= bus.wWrEn;
                        ptr         <= '0;
                        state       <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.wClear) begin
                        // Abort: back to IDLE silently, no completion pulse.
                        ptr   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                        if (ptr == LAST_PTR) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Bus mux: select the held bus, its group and its enable for the current slot.
    // NOTE: each output gets a default before any conditional logic so no path
    // leaves a value unassigned, which would otherwise infer a latch.
    always_comb begin
        wr_en   = 1'b0;
        wr_grp  = '0;
        wr_data = '0;
        if (state == ST_WRITE) begin
            wr_en   = held_en[ptr] && !bus.wClear;
            wr_grp  = held_dest[ptr*GRP_W +: GRP_W];
            wr_data = held_bus[ptr];
        end
    end

    regs_bank #(
        .DATA_WIDTH      (DATA_WIDTH),
        .REGS_INPUTS     (REGS_INPUTS),
        .OUTPUTS_PER_BUS (OUTPUTS_PER_BUS)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_grp  (wr_grp),
        .wr_data (wr_data),
        .clear   (bus.wClear),
        .regs    (bus.wRegs)
    );

    // Busy is a pure decode of the state register, so it is glitch-free and registered.
    assign bus.wBusy = (state == ST_WRITE);
    assign bus.wDone = done;

endmodule

// File: tb/tb_regs_writeback.sv
// Scoreboard bench for regs_writeback: accepted transactions push the expected
// bank image; a monitor pops and compares on every wDone pulse.
module tb_regs_writeback;

    localparam int DW    = 4;
    localparam int NREG  = 64;
    localparam int PER   = 4;
    localparam int BANKW = NREG * DW;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    regs_writeback_if #(.DATA_WIDTH(DW), .REGS_INPUTS(NREG), .OUTPUTS_PER_BUS(PER)) bus ();

    regs_writeback #(.DATA_WIDTH(DW), .REGS_INPUTS(NREG), .OUTPUTS_PER_BUS(PER)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [BANKW-1:0] model;
    logic [BANKW-1:0] exp_q [$];

    task automatic check(input string name, input logic [BANKW-1:0] act, input logic [BANKW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest expected bank image.
    always @(negedge clk) begin
        if (reset === 1'b0 && bus.wDone === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("done_without_txn", BANKW'(exp_q.size() + 1), BANKW'(0));
            end else begin
                check("done_bank", bus.wRegs, exp_q.pop_front());
            end
        end
    end

    // Drive one transaction for one edge; returns #1 into the cycle after the capture edge.
    task automatic send(input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                        input logic [15:0] a3, input logic [15:0] dest, input logic [3:0] en,
                        input bit expect_accept);
        logic [15:0] rr [4];
        rr = '{a0, a1, a2, a3};
        bus.r0 = a0; bus.r1 = a1; bus.r2 = a2; bus.r3 = a3;
        bus.wDest = dest;
        bus.wWrEn = en;
        bus.wValid = 1'b1;
        if (expect_accept) begin
            for (int i = 0; i < 4; i++) begin
                if (en[i]) model[int'(dest[i*4 +: 4])*16 +: 16] = rr[i];
            end
            exp_q.push_back(model);
        end
        @(posedge clk); #1;
        bus.wValid = 1'b0;
    endtask

    // Bounded wait for wDone, polled 1 time unit after each edge.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.wDone === 1'b1) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check({name, "_done_seen"}, BANKW'(seen), BANKW'(1));
    endtask

    // Single-write scenario with exact busy/done timing and hand-computed bank slice.
    task automatic single_write(input string name);
        send(16'hA5C3, 16'h0, 16'h0, 16'h0, 16'h0002, 4'b0001, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            check({name, "_busy_high"}, BANKW'(bus.wBusy), BANKW'(1));
            check({name, "_done_low"}, BANKW'(bus.wDone), BANKW'(0));
            @(posedge clk); #1;
        end
        check({name, "_busy_low"}, BANKW'(bus.wBusy), BANKW'(0));
        check({name, "_done_pulse"}, BANKW'(bus.wDone), BANKW'(1));
        check({name, "_regs8_11"}, BANKW'(bus.wRegs[32 +: 16]), BANKW'(16'hA5C3));
    endtask

    int done_cnt;

    initial begin
        reset = 1'b1;
        bus.wValid = 1'b0; bus.wClear = 1'b0;
        bus.r0 = '0; bus.r1 = '0; bus.r2 = '0; bus.r3 = '0;
        bus.wDest = '0; bus.wWrEn = '0;
        model = '0;

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        check("reset_regs", bus.wRegs, '0);
        check("reset_busy", BANKW'(bus.wBusy), BANKW'(0));
        check("reset_done", BANKW'(bus.wDone), BANKW'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // Single write into group 2
        single_write("single");
        @(posedge clk); #1;

        // Conflict: buses 1 and 3 both target group 5, bus 3 wins
        send(16'h0, 16'h1111, 16'h0, 16'h2222, 16'h5050, 4'b1010, 1'b1);
        wait_done("conflict");
        check("conflict_regs20_23", BANKW'(bus.wRegs[80 +: 16]), BANKW'(16'h2222));
        @(posedge clk); #1;

        // All enables off: full sequence, bank unchanged, done still pulses
        send(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h3210, 4'b0000, 1'b1);
        check("noen_busy", BANKW'(bus.wBusy), BANKW'(1));
        wait_done("noen");
        check("noen_bank", bus.wRegs, model);
        @(posedge clk); #1;

        // Busy drop, then back-to-back acceptance in the done cycle
        send(16'h1234, 16'h0, 16'h0, 16'h0, 16'h0001, 4'b0001, 1'b1);
        @(posedge clk); #1;
        bus.r0 = 16'hFFFF; bus.wDest = 16'h0003; bus.wWrEn = 4'b0001; bus.wValid = 1'b1;
        @(posedge clk); #1;
        bus.wValid = 1'b0;
        wait_done("drop_first");
        check("drop_grp3_untouched", BANKW'(bus.wRegs[48 +: 16]), BANKW'(16'h0000));
        check("drop_grp1", BANKW'(bus.wRegs[16 +: 16]), BANKW'(16'h1234));
        send(16'h9876, 16'h0, 16'h0, 16'h0, 16'h0006, 4'b0001, 1'b1);
        check("b2b_busy", BANKW'(bus.wBusy), BANKW'(1));
        wait_done("b2b");
        check("b2b_grp6", BANKW'(bus.wRegs[96 +: 16]), BANKW'(16'h9876));
        @(posedge clk); #1;

        // Clear in IDLE with simultaneous wValid: bank wiped, valid dropped
        bus.wClear = 1'b1;
        bus.r0 = 16'hBEEF; bus.wDest = 16'h0004; bus.wWrEn = 4'b0001; bus.wValid = 1'b1;
        @(posedge clk); #1;
        bus.wClear = 1'b0; bus.wValid = 1'b0;
        model = '0;
        check("idle_clear_bank", bus.wRegs, '0);
        check("idle_clear_busy", BANKW'(bus.wBusy), BANKW'(0));
        @(posedge clk); #1;

        // Clear abort in T+2 of a four-bus write
        send(16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'hA987, 4'b1111, 1'b0);
        @(posedge clk); #1;
        bus.wClear = 1'b1;
        @(posedge clk); #1;
        bus.wClear = 1'b0;
        check("abort_bank", bus.wRegs, '0);
        check("abort_busy", BANKW'(bus.wBusy), BANKW'(0));
        done_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.wDone === 1'b1) done_cnt++;
            @(posedge clk); #1;
        end
        check("abort_no_done", BANKW'(done_cnt), BANKW'(0));
        check("abort_bank_stays", bus.wRegs, '0);

        // Reset in T+3 of a four-bus write
        send(16'h5555, 16'h6666, 16'h7777, 16'h8888, 16'h4321, 4'b1111, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        #2 reset = 1'b1;
        #1;
        check("midrst_regs", bus.wRegs, '0);
        check("midrst_busy", BANKW'(bus.wBusy), BANKW'(0));
        check("midrst_done", BANKW'(bus.wDone), BANKW'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        model = '0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("postrst_regs", bus.wRegs, '0);
        check("postrst_busy", BANKW'(bus.wBusy), BANKW'(0));
        single_write("postrst");

        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        check("queue_drained", BANKW'(exp_q.size()), BANKW'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
